// File: rtl/vga_scanout.sv
// VGA scanout: 640x480@60 timing, 1bpp VRAM fetch, pixel-replicated window at top-left.
// Latency 3 cycles counter->outputs; free-running, no backpressure. `VGA_BORDER_EN adds a blue border.
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FB_W       = 128,
  parameter int FB_H       = 64,
  parameter int SCALE_LOG2 = 2
) (
  input  logic        vclk,
  input  logic        rst,
  output logic [15:0] vaddr,
  input  logic [15:0] vout,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [2:0]  rgb,
  output logic        frame_start
);

  localparam logic [11:0] H_TOTAL = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] V_TOTAL = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] HS_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] WIN_W   = 12'(FB_W << SCALE_LOG2);
  localparam logic [11:0] WIN_H   = 12'(FB_H << SCALE_LOG2);
  localparam logic [13:0] WPR     = 14'(FB_W / 16);

  typedef struct packed {
    logic       active;
    logic       win;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [3:0] bitidx;
  } stage_t;

  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  stage_t      st0, s1_q, s2_q;
  logic [13:0] addr_lo;
  logic [15:0] vaddr_q, vaddr_d;
  logic        hsync_q, vsync_q, de_q, fs_q;
  logic [2:0]  rgb_q, rgb_d;

  always_comb begin
    hcnt_d = hcnt_q + 12'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_TOTAL - 12'd1) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_TOTAL - 12'd1) ? 12'd0 : vcnt_q + 12'd1;
    end
  end

  always_comb begin
    st0.active = (hcnt_q < 12'(H_ACTIVE)) && (vcnt_q < 12'(V_ACTIVE));
    st0.win    = (hcnt_q < WIN_W) && (vcnt_q < WIN_H);
    st0.hs     = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    st0.vs     = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    st0.fs     = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
    st0.bitidx = 4'd15 - hcnt_q[SCALE_LOG2 +: 4];
  end

  // Word address of the framebuffer cell under the beam; held outside the window.
  assign addr_lo = 14'(vcnt_q >> SCALE_LOG2) * WPR + 14'(hcnt_q >> (SCALE_LOG2 + 4));
  assign vaddr_d = st0.win ? {2'b11, addr_lo} : vaddr_q;

  always_comb begin
    rgb_d = 3'b000;
    if (s2_q.active && s2_q.win && vout[s2_q.bitidx]) begin
      rgb_d = 3'b111;
    end
`ifdef VGA_BORDER_EN
    else if (s2_q.active && !s2_q.win) begin
      rgb_d = 3'b001;
    end
`endif
  end

  always_ff @(posedge vclk or negedge rst) begin
    if (!rst) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      vaddr_q <= 16'hC000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= 3'b000;
      fs_q    <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      s1_q    <= st0;
      s2_q    <= s1_q;
      vaddr_q <= vaddr_d;
      hsync_q <= ~s2_q.hs;
      vsync_q <= ~s2_q.vs;
      de_q    <= s2_q.active;
      rgb_q   <= rgb_d;
      fs_q    <= s2_q.fs;
    end
  end

  assign vaddr       = vaddr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;

endmodule
